// File: rtl/crc32_pkg.sv
// Shared CRC-32 (IEEE 802.3, reflected) constants, FSM encodings and the
// byte-step update used by the stream engine.
package crc32_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t FRAME = 1'b1;

  // One byte of the reflected CRC, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_stream_engine_step.sv
// Combinational multi-byte CRC update: chains crc32_byte over the first
// 'cnt' bytes of the beat, byte 0 first.
module crc32_step #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [31:0]                       crc_in,
  input  logic [DATA_W-1:0]                 data,
  input  logic [$clog2(DATA_W/8+1)-1:0]     cnt,
  output logic [31:0]                       crc_out
);
  import crc32_pkg::*;

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  logic [31:0] crc_v;

  always_comb begin
    crc_v = crc_in;
    for (int unsigned i = 0; i < NB; i++) begin
      if (CNT_W'(i) < cnt) begin
        crc_v = crc32_byte(crc_v, data[8*i +: 8]);
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/crc32_stream_engine.sv
// Framed-stream CRC-32 generator/checker with keep decode, saturating byte
// length, protocol-error pulse and a single-entry result register.
module crc32_stream_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_sop,
  input  logic                s_eop,
  input  logic                chk_mode,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [31:0]         res_crc,
  output logic                res_ok,
  output logic [LEN_W-1:0]    res_len,
  output logic                proto_err
);
  import crc32_pkg::*;

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  state_t             state_q,     state_d;
  logic [31:0]        crc_q,       crc_d;
  logic [LEN_W-1:0]   len_q,       len_d;
  logic               chk_q,       chk_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_crc_q,   res_crc_d;
  logic               res_ok_q,    res_ok_d;
  logic [LEN_W-1:0]   res_len_q,   res_len_d;
  logic               proto_err_q, proto_err_d;

  logic               accept_c;
  logic [CNT_W-1:0]   keep_cnt_c;
  logic [NB-1:0]      keep_mask_c;
  logic               keep_err_c;
  logic               keep_run_c;
  logic [CNT_W-1:0]   beat_cnt_c;
  logic [31:0]        step_in_c;
  logic [31:0]        step_out_c;
  logic [LEN_W-1:0]   len_base_c;
  logic [LEN_W:0]     len_sum_c;
  logic [LEN_W-1:0]   len_new_c;
  logic               chk_eff_c;

  // A held result blocks the whole input until it is consumed.
  assign s_ready  = ~res_valid_q | res_ready;
  assign accept_c = s_valid & s_ready;

  // Lowest contiguous run of keep bits; anything else is a framing error.
  always_comb begin
    keep_cnt_c  = '0;
    keep_mask_c = '0;
    keep_run_c  = 1'b1;
    for (int unsigned i = 0; i < NB; i++) begin
      if (keep_run_c && s_keep[i]) begin
        keep_cnt_c     = keep_cnt_c + CNT_W'(1);
        keep_mask_c[i] = 1'b1;
      end else begin
        keep_run_c = 1'b0;
      end
    end
    keep_err_c = (s_keep == '0) || (s_keep != keep_mask_c);
  end

  assign beat_cnt_c = s_eop ? keep_cnt_c : CNT_W'(NB);
  assign step_in_c  = s_sop ? CRC_INIT : crc_q;
  assign len_base_c = s_sop ? '0 : len_q;
  assign len_sum_c  = {1'b0, len_base_c} + (LEN_W+1)'(beat_cnt_c);
  assign len_new_c  = len_sum_c[LEN_W] ? '1 : len_sum_c[LEN_W-1:0];
  assign chk_eff_c  = s_sop ? chk_mode : chk_q;

  crc32_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .crc_in  (step_in_c),
    .data    (s_data),
    .cnt     (beat_cnt_c),
    .crc_out (step_out_c)
  );

  // Next-state and datapath update for an accepted beat.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    chk_d       = chk_q;
    res_valid_d = res_valid_q & ~res_ready;
    res_crc_d   = res_crc_q;
    res_ok_d    = res_ok_q;
    res_len_d   = res_len_q;
    proto_err_d = 1'b0;

    if (accept_c) begin
      if (!s_sop && state_q == IDLE) begin
        proto_err_d = 1'b1;
      end else begin
        if (s_sop) begin
          chk_d = chk_mode;
          if (state_q == FRAME) begin
            proto_err_d = 1'b1;
          end
        end
        if (s_eop) begin
          if (keep_err_c) begin
            proto_err_d = 1'b1;
          end
          res_valid_d = 1'b1;
          res_crc_d   = step_out_c ^ CRC_XOROUT;
          res_ok_d    = chk_eff_c ? (step_out_c == CRC_RESIDUE) : 1'b1;
          res_len_d   = len_new_c;
          crc_d       = CRC_INIT;
          len_d       = '0;
          state_d     = IDLE;
        end else begin
          crc_d   = step_out_c;
          len_d   = len_new_c;
          state_d = FRAME;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      chk_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_ok_q    <= 1'b0;
      res_len_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      res_valid_q <= res_valid_d;
      res_crc_q   <= res_crc_d;
      res_ok_q    <= res_ok_d;
      res_len_q   <= res_len_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_crc   = res_crc_q;
  assign res_ok    = res_ok_q;
  assign res_len   = res_len_q;
  assign proto_err = proto_err_q;

endmodule

// File: doc/crc32_stream_engine.md
# crc32_stream_engine

Parametrised successor to the team's byte-wise CRC-32 generator. It computes IEEE 802.3 CRC-32 over a framed stream whose data bus is DATA_W bits wide, with per-byte keep on the final beat. It runs in either generate mode (reports the FCS) or check mode (validates a frame whose FCS is already appended), and reports frame length and protocol errors. It sits beside the PHY-side MAC datapath as a passive tap with a result handshake.

## Interface
- DATA_W, 8: input bus width. Legal values are 8, 16, 32 and 64.
- LEN_W, 16: width of the byte-length counter.
- clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  DATA_W  beat data. Byte 0 is [7:0] and is processed first.
- s_keep  in  DATA_W/8  byte enables. Honoured on the eop beat only; ignored otherwise.
- s_sop  in  1  first beat of frame.
- s_eop  in  1  last beat of frame.
- chk_mode  in  1  0 = generate, 1 = check. Sampled on the accepted sop beat.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_crc  out  32  final CRC (register XOR 0xFFFFFFFF).
- res_ok  out  1  check mode: residue matched. Generate mode: always 1.
- res_len  out  LEN_W  bytes accepted in the frame. Saturates at all-ones.
- proto_err  out  1  one-cycle pulse on a framing violation.

## Operation
- Algorithm: reflected CRC-32. Polynomial 0xEDB88320 (reflected 0x04C11DB7), init 0xFFFFFFFF, xorout 0xFFFFFFFF, data LSB-first per byte.
- State machine:
  - IDLE: waiting for sop.
  - FRAME: accumulating.
- IDLE, accepted sop beat: load the CRC register with init, then apply the beat's bytes. Latch chk_mode. Set len to the beat's byte count. If eop is also set, finish the frame; otherwise go to FRAME.
- FRAME, accepted beat without sop: fold in all DATA_W/8 bytes, or only the keep bytes if eop. len += byte count.
- On an eop beat, load the result register:
  - res_crc = ~crc.
  - res_ok = (raw crc == 0xDEBB20E3) if check mode, else 1.
  - res_len = len.
  - Then go to IDLE.
- Keep on eop must be contiguous from bit 0 (e.g. 0001, 0011, 0111, 1111).
  - Non-contiguous: use the count of the lowest contiguous run and pulse proto_err.
  - keep = 0: zero bytes are added, the frame still closes, and proto_err pulses.
- Beat without sop in IDLE: dropped (still accepted), proto_err pulses.
- sop in FRAME: the current frame is abandoned with no result, the new frame starts from that beat, and proto_err pulses.
- Result register is a single entry. s_ready = ~res_valid | res_ready. Backpressure stalls the whole input, not only eop beats.
- Length saturates at 2^LEN_W-1 and never wraps.

## Timing
- Reset values:
  - s_ready = 1, res_valid = 0, res_crc = 0, res_ok = 0, res_len = 0, proto_err = 0.
  - State = IDLE, CRC register = 0xFFFFFFFF.
- Throughput is one beat per cycle. The update is single-cycle combinational over up to 8 bytes, with no internal pipeline.
- Latency: res_valid rises on the clock edge that accepts the eop beat, so results are visible the following cycle.
- res_* hold stable while res_valid & ~res_ready.
- An eop beat accepted in the same cycle the previous result is consumed reloads the result register back-to-back; res_valid stays 1.
- proto_err is registered and asserts on the cycle after the offending beat.
- rst mid-frame clears everything immediately. The partial frame is lost and no result is produced.

## Structure
- Package crc32_pkg holds:
  - constants CRC_POLY_REFL = 32'hEDB88320, CRC_INIT = 32'hFFFFFFFF, CRC_XOROUT = 32'hFFFFFFFF, CRC_RESIDUE = 32'hDEBB20E3;
  - function crc32_byte(crc, byte) that returns the 8-bit-step update;
  - the state enum {IDLE, FRAME}.
- One sub-module, crc32_step. It is combinational and parametrised by DATA_W. Inputs are crc_in, data and an active-byte count; output is crc_out, formed by chaining crc32_byte over the active bytes in order.
- The top level holds the FSM, length counter, keep decode and result register.

## Test plan
- DATA_W=8, ASCII "123456789" (bytes 0x31..0x39), generate mode -> res_crc=0xCBF43926, res_len=9, res_ok=1.
- DATA_W=32, the same string in 3 beats with last keep=0001 -> res_crc=0xCBF43926, res_len=9. Repeat at DATA_W=64 with last keep=00000001 -> same result.
- Check mode, "123456789" followed by 0x26,0x39,0xF4,0xCB -> res_ok=1, res_len=13. Flip bit 0 of byte 3 -> res_ok=0.
- Hold res_ready=0 across two back-to-back frames:
  - s_ready drops after the first eop;
  - the first result stays stable;
  - after res_ready, the second frame proceeds and no beats are lost.
- Framing errors, each producing one proto_err pulse:
  - beat without sop in IDLE -> one pulse, no result;
  - sop mid-frame -> one pulse, only the second frame's result appears;
  - eop with keep=0101 -> one pulse, 1 byte counted.
- Assert rst during beat 2 of a 3-beat frame -> all outputs at reset values. A following clean frame gives the correct CRC.
